// File: rtl/bram_dp_pipe.sv
// Pipelined true dual-port RAM with valid/ready handshakes, byte strobes and collision counter.
// Optional macro BRAM_COLL_STALL_EN: stall port A on same-address overlapping writes.
module bram_dp_port #(
  parameter int DW      = 32,
  parameter int OUT_REG = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          acc_i,
  input  logic [DW-1:0] data_i,
  input  logic          rsp_ready_i,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          frozen_o
);
  logic frz;

  assign frz      = rsp_valid_o && !rsp_ready_i;
  assign frozen_o = frz;

  if (OUT_REG == 0) begin : g_lat1
    logic          v_q;
    logic [DW-1:0] d_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (!frz) begin
        v_q <= acc_i;
        if (acc_i) d_q <= data_i;
      end
    end

    assign rsp_valid_o = v_q;
    assign rsp_rdata_o = d_q;
  end else begin : g_lat2
    logic          v1_q, v2_q;
    logic [DW-1:0] d1_q, d2_q;

    // Both stages move together so a freeze holds the whole pipe.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v1_q <= 1'b0;
        v2_q <= 1'b0;
        d1_q <= '0;
        d2_q <= '0;
      end else if (!frz) begin
        v1_q <= acc_i;
        if (acc_i) d1_q <= data_i;
        v2_q <= v1_q;
        if (v1_q) d2_q <= d1_q;
      end
    end

    assign rsp_valid_o = v2_q;
    assign rsp_rdata_o = d2_q;
  end
endmodule

module bram_dp_pipe #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int OUT_REG     = 0,
  parameter int WRITE_FIRST = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_a_valid,
  output logic                    req_a_ready,
  input  logic                    req_a_we,
  input  logic [DATA_WIDTH/8-1:0] req_a_wstrb,
  input  logic [ADDR_WIDTH-1:0]   req_a_addr,
  input  logic [DATA_WIDTH-1:0]   req_a_wdata,
  output logic                    rsp_a_valid,
  input  logic                    rsp_a_ready,
  output logic [DATA_WIDTH-1:0]   rsp_a_rdata,
  input  logic                    req_b_valid,
  output logic                    req_b_ready,
  input  logic                    req_b_we,
  input  logic [DATA_WIDTH/8-1:0] req_b_wstrb,
  input  logic [ADDR_WIDTH-1:0]   req_b_addr,
  input  logic [DATA_WIDTH-1:0]   req_b_wdata,
  output logic                    rsp_b_valid,
  input  logic                    rsp_b_ready,
  output logic [DATA_WIDTH-1:0]   rsp_b_rdata,
  output logic [15:0]             coll_cnt
);
  localparam int SW    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] old_a, old_b, rd_a, rd_b;
  logic                  frz_a, frz_b, rdy_a, rdy_b;
  logic                  acc_a, acc_b, same_wr, coll_evt;
  logic [15:0]           coll_q, coll_d;

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] o,
    input logic [DATA_WIDTH-1:0] n,
    input logic [SW-1:0]         s
  );
    logic [DATA_WIDTH-1:0] r;
    r = o;
    for (int i = 0; i < SW; i++)
      if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  assign rdy_a = rst_n && !frz_a;
  assign rdy_b = rst_n && !frz_b;

  assign same_wr = req_a_we && req_b_we
                && (req_a_addr == req_b_addr)
                && |(req_a_wstrb & req_b_wstrb);

`ifdef BRAM_COLL_STALL_EN
  logic stall;
  assign stall       = req_a_valid && req_b_valid && same_wr && rdy_b;
  assign req_a_ready = rdy_a && !stall;
  assign coll_evt    = stall;
`else
  assign req_a_ready = rdy_a;
  assign coll_evt    = acc_a && acc_b && same_wr;
`endif

  assign req_b_ready = rdy_b;
  assign acc_a       = req_a_valid && req_a_ready;
  assign acc_b       = req_b_valid && req_b_ready;

  assign old_a = mem_q[req_a_addr];
  assign old_b = mem_q[req_b_addr];

  assign rd_a = (req_a_we && WRITE_FIRST != 0)
              ? merge(old_a, req_a_wdata, req_a_wstrb) : old_a;
  assign rd_b = (req_b_we && WRITE_FIRST != 0)
              ? merge(old_b, req_b_wdata, req_b_wstrb) : old_b;

  // B's lanes are assigned last so B wins on overlapping bytes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SW; i++) begin
      if (acc_a && req_a_we && req_a_wstrb[i])
        mem_q[req_a_addr][i*8 +: 8] <= req_a_wdata[i*8 +: 8];
      if (acc_b && req_b_we && req_b_wstrb[i])
        mem_q[req_b_addr][i*8 +: 8] <= req_b_wdata[i*8 +: 8];
    end
  end

  always_comb begin
    coll_d = coll_q;
    if (coll_evt && coll_q != 16'hFFFF) coll_d = coll_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) coll_q <= '0;
    else        coll_q <= coll_d;
  end

  assign coll_cnt = coll_q;

  bram_dp_port #(.DW(DATA_WIDTH), .OUT_REG(OUT_REG)) u_port_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .acc_i      (acc_a),
    .data_i     (rd_a),
    .rsp_ready_i(rsp_a_ready),
    .rsp_valid_o(rsp_a_valid),
    .rsp_rdata_o(rsp_a_rdata),
    .frozen_o   (frz_a)
  );

  bram_dp_port #(.DW(DATA_WIDTH), .OUT_REG(OUT_REG)) u_port_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .acc_i      (acc_b),
    .data_i     (rd_b),
    .rsp_ready_i(rsp_b_ready),
    .rsp_valid_o(rsp_b_valid),
    .rsp_rdata_o(rsp_b_rdata),
    .frozen_o   (frz_b)
  );
endmodule

// File: tb/tb_bram_dp_pipe.sv
// Directed bench for bram_dp_pipe: one 1-cycle/read-first instance
// and one 2-cycle/write-first instance.
module tb_bram_dp_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_valid, a_ready, a_we, a_rv, a_rr;
  logic [3:0]  a_strb;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        b_valid, b_ready, b_we, b_rv, b_rr;
  logic [3:0]  b_strb;
  logic [9:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic [15:0] coll0;

  logic        c_valid, c_ready, c_we, c_rv, c_rr;
  logic [3:0]  c_strb;
  logic [9:0]  c_addr;
  logic [31:0] c_wdata, c_rdata;
  logic        d_valid, d_ready, d_we, d_rv, d_rr;
  logic [3:0]  d_strb;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic [15:0] coll1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bram_dp_pipe u0 (
    .clk(clk), .rst_n(rst_n),
    .req_a_valid(a_valid), .req_a_ready(a_ready), .req_a_we(a_we),
    .req_a_wstrb(a_strb), .req_a_addr(a_addr), .req_a_wdata(a_wdata),
    .rsp_a_valid(a_rv), .rsp_a_ready(a_rr), .rsp_a_rdata(a_rdata),
    .req_b_valid(b_valid), .req_b_ready(b_ready), .req_b_we(b_we),
    .req_b_wstrb(b_strb), .req_b_addr(b_addr), .req_b_wdata(b_wdata),
    .rsp_b_valid(b_rv), .rsp_b_ready(b_rr), .rsp_b_rdata(b_rdata),
    .coll_cnt(coll0)
  );

  bram_dp_pipe #(.OUT_REG(1), .WRITE_FIRST(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_a_valid(c_valid), .req_a_ready(c_ready), .req_a_we(c_we),
    .req_a_wstrb(c_strb), .req_a_addr(c_addr), .req_a_wdata(c_wdata),
    .rsp_a_valid(c_rv), .rsp_a_ready(c_rr), .rsp_a_rdata(c_rdata),
    .req_b_valid(d_valid), .req_b_ready(d_ready), .req_b_we(d_we),
    .req_b_wstrb(d_strb), .req_b_addr(d_addr), .req_b_wdata(d_wdata),
    .rsp_b_valid(d_rv), .rsp_b_ready(d_rr), .rsp_b_rdata(d_rdata),
    .coll_cnt(coll1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic a_req(input logic we, input logic [9:0] ad,
                       input logic [31:0] wd, input logic [3:0] st);
    a_valid = 1'b1; a_we = we; a_addr = ad; a_wdata = wd; a_strb = st;
  endtask

  task automatic b_req(input logic we, input logic [9:0] ad,
                       input logic [31:0] wd, input logic [3:0] st);
    b_valid = 1'b1; b_we = we; b_addr = ad; b_wdata = wd; b_strb = st;
  endtask

  // One isolated request on u1 port A: response exactly 2 edges later.
  task automatic c_op(input string tag, input logic we,
                      input logic [9:0] ad, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] exp);
    c_valid = 1'b1; c_we = we; c_addr = ad; c_wdata = wd; c_strb = st;
    tick();
    c_valid = 1'b0;
    chk({tag, "_early"}, {31'd0, c_rv}, 32'd0);
    tick();
    chk({tag, "_v"}, {31'd0, c_rv}, 32'd1);
    chk({tag, "_d"}, c_rdata, exp);
    tick();
    chk({tag, "_end"}, {31'd0, c_rv}, 32'd0);
  endtask

  initial begin
    a_valid = 0; a_we = 0; a_strb = 0; a_addr = 0; a_wdata = 0; a_rr = 1;
    b_valid = 0; b_we = 0; b_strb = 0; b_addr = 0; b_wdata = 0; b_rr = 1;
    c_valid = 0; c_we = 0; c_strb = 0; c_addr = 0; c_wdata = 0; c_rr = 1;
    d_valid = 0; d_we = 0; d_strb = 0; d_addr = 0; d_wdata = 0; d_rr = 1;

    // Reset state
    a_valid = 1'b1;
    tick(); tick();
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_a_rv", {31'd0, a_rv}, 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_rv", {31'd0, b_rv}, 32'd0);
    chk("rst_coll", {16'd0, coll0}, 32'd0);
    chk("rst_c_rdata", c_rdata, 32'd0);
    a_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_a_ready", {31'd0, a_ready}, 32'd1);
    tick();
    chk("post_rst_a_rv", {31'd0, a_rv}, 32'd0);

    // Full write then read-back, 1-cycle latency
    a_req(1, 10'd5, 32'hDEADBEEF, 4'hF);
    tick();
    chk("wr1_rv", {31'd0, a_rv}, 32'd1);
    a_req(0, 10'd5, 32'h0, 4'h0);
    tick();
    a_valid = 1'b0;
    chk("rd1_rv", {31'd0, a_rv}, 32'd1);
    chk("rd1_d", a_rdata, 32'hDEADBEEF);
    tick();
    chk("rd1_end", {31'd0, a_rv}, 32'd0);
    chk("rd1_coll", {16'd0, coll0}, 32'd0);

    // Partial strobe, read-first response
    a_req(1, 10'd5, 32'h11223344, 4'h3);
    tick();
    a_valid = 1'b0;
    chk("wr2_old", a_rdata, 32'hDEADBEEF);
    a_req(0, 10'd5, 32'h0, 4'h0);
    tick();
    a_valid = 1'b0;
    chk("rd2_d", a_rdata, 32'hDEAD3344);

    // Zero strobe write still responds, memory untouched
    a_req(1, 10'd5, 32'hFFFFFFFF, 4'h0);
    tick();
    a_valid = 1'b0;
    chk("wr0_rv", {31'd0, a_rv}, 32'd1);
    chk("wr0_d", a_rdata, 32'hDEAD3344);
    b_req(0, 10'd5, 32'h0, 4'h0);
    tick();
    b_valid = 1'b0;
    chk("wr0_rb", b_rdata, 32'hDEAD3344);

    // Cross-port: B reading while A writes sees old word
    a_req(1, 10'd5, 32'hCAFEF00D, 4'hF);
    b_req(0, 10'd5, 32'h0, 4'h0);
    tick();
    a_valid = 1'b0;
    chk("xp_old", b_rdata, 32'hDEAD3344);
    chk("xp_coll", {16'd0, coll0}, 32'd0);
    tick();
    b_valid = 1'b0;
    chk("xp_new", b_rdata, 32'hCAFEF00D);

    // Backpressure on B does not stall A
    b_req(0, 10'd5, 32'h0, 4'h0);
    tick();
    b_valid = 1'b0;
    b_rr = 1'b0;
    #1;
    chk("bp_b_ready", {31'd0, b_ready}, 32'd0);
    chk("bp_a_ready", {31'd0, a_ready}, 32'd1);
    tick();
    chk("bp_b_hold_v", {31'd0, b_rv}, 32'd1);
    chk("bp_b_hold_d", b_rdata, 32'hCAFEF00D);
    b_rr = 1'b1;
    tick();
    chk("bp_b_done", {31'd0, b_rv}, 32'd0);

    // Same-cycle overlapping writes to addr 9
    a_req(1, 10'd9, 32'hAAAAAAAA, 4'hF);
    b_req(1, 10'd9, 32'h55555555, 4'hC);
    #1;
`ifdef BRAM_COLL_STALL_EN
    chk("coll_stall", {31'd0, a_ready}, 32'd0);
    tick();
    b_valid = 1'b0;
    #1;
    chk("coll_a_go", {31'd0, a_ready}, 32'd1);
    tick();
    a_valid = 1'b0;
`else
    chk("coll_no_stall", {31'd0, a_ready}, 32'd1);
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
`endif
    chk("coll_cnt1", {16'd0, coll0}, 32'd1);
    a_req(0, 10'd9, 32'h0, 4'h0);
    tick();
    a_valid = 1'b0;
`ifdef BRAM_COLL_STALL_EN
    chk("coll_rd", a_rdata, 32'hAAAAAAAA);
`else
    chk("coll_rd", a_rdata, 32'h5555AAAA);
`endif

    // Write-first, 2-cycle instance
    for (int i = 0; i < 4; i++)
      c_op("c_fill", 1'b1, 10'(i), 32'hA0 + i, 4'hF, 32'hA0 + i);
    c_op("c_wr5", 1'b1, 10'd5, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF);
    c_op("c_wf", 1'b1, 10'd5, 32'h11223344, 4'h3, 32'hDEAD3344);
    c_op("c_rd5", 1'b0, 10'd5, 32'h0, 4'h0, 32'hDEAD3344);

    // Back-to-back reads 0..3, consumer stalls from the 2nd response
    c_valid = 1'b1; c_we = 1'b0; c_addr = 10'd0;
    tick();
    chk("bb_r0_lat", {31'd0, c_rv}, 32'd0);
    c_addr = 10'd1;
    tick();
    chk("bb_r0", c_rdata, 32'hA0);
    c_addr = 10'd2;
    tick();
    chk("bb_r1_v", {31'd0, c_rv}, 32'd1);
    chk("bb_r1", c_rdata, 32'hA1);
    c_rr = 1'b0;
    c_addr = 10'd3;
    #1;
    chk("bb_frz_ready", {31'd0, c_ready}, 32'd0);
    chk("bb_d_ready", {31'd0, d_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bb_hold_v", {31'd0, c_rv}, 32'd1);
      chk("bb_hold_d", c_rdata, 32'hA1);
      chk("bb_hold_rdy", {31'd0, c_ready}, 32'd0);
    end
    c_rr = 1'b1;
    #1;
    chk("bb_rel_ready", {31'd0, c_ready}, 32'd1);
    tick();
    c_valid = 1'b0;
    chk("bb_r2", c_rdata, 32'hA2);
    tick();
    chk("bb_r3_v", {31'd0, c_rv}, 32'd1);
    chk("bb_r3", c_rdata, 32'hA3);
    tick();
    chk("bb_drain", {31'd0, c_rv}, 32'd0);

    // Reset with two reads in flight
    c_valid = 1'b1; c_we = 1'b0; c_addr = 10'd5;
    tick();
    c_addr = 10'd0;
    tick();
    c_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_ready_low", {31'd0, c_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    chk("mr_v0", {31'd0, c_rv}, 32'd0);
    chk("mr_coll", {16'd0, coll1}, 32'd0);
    tick();
    chk("mr_v1", {31'd0, c_rv}, 32'd0);
    tick();
    chk("mr_v2", {31'd0, c_rv}, 32'd0);
    c_op("mr_keep", 1'b0, 10'd5, 32'h0, 4'h0, 32'hDEAD3344);

    // Saturating collision counter
    chk("sat_start", {16'd0, coll0}, 32'd0);
    a_req(1, 10'd20, 32'h01010101, 4'hF);
    b_req(1, 10'd20, 32'h02020202, 4'hF);
    repeat (65534) tick();
    chk("sat_fffe", {16'd0, coll0}, 32'h0000FFFE);
    repeat (6) tick();
    chk("sat_ffff", {16'd0, coll0}, 32'h0000FFFF);
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    chk("sat_hold", {16'd0, coll0}, 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
